// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter: grants one of four byte-stream requesters
// exclusive access to a shared FIFO for one packet or up to MAX_BURST bytes,
// with a flush path that aborts the current packet and clears the FIFO.
module fifo_wr_arbiter #(
    parameter int unsigned MAX_BURST = 16
) (
    input  logic        clock,
    input  logic        sclr,
    input  logic [3:0]  req_valid,
    input  logic [31:0] req_data,
    input  logic [3:0]  req_last,
    output logic [3:0]  req_ready,
    input  logic        flush,
    input  logic        fifo_full,
    output logic        fifo_wrreq,
    output logic [7:0]  fifo_data,
    output logic        fifo_sclr_n,
    output logic [1:0]  grant_id,
    output logic        busy
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] LOCK  = 2'd1;
    localparam logic [1:0] FLUSH = 2'd2;

    localparam logic [7:0] MAX_BURST_B = 8'(MAX_BURST);

    logic [1:0] state_q, state_d;
    logic [1:0] owner_q, owner_d;
    logic [1:0] last_owner_q, last_owner_d;
    logic [7:0] burst_cnt_q, burst_cnt_d;
    logic [1:0] grant_id_q, grant_id_d;
    // High while one more clear cycle remains after the current one.
    logic       clr_cnt_q, clr_cnt_d;
    logic       fifo_sclr_n_q, fifo_sclr_n_d;

    logic       pick_valid;
    logic [1:0] pick_idx;
    logic [1:0] cand;
    logic       lock_open;
    logic       xfer;
    logic [7:0] burst_inc;

    // Round-robin pick: first valid requester after last_owner, wrapping.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = last_owner_q;
        cand       = last_owner_q;
        for (int unsigned k = 1; k <= 4; k++) begin
            cand = last_owner_q + 2'(k);
            if (!pick_valid && req_valid[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    // Handshake and FIFO write path; reset and flush block any transfer.
    always_comb begin
        lock_open  = (state_q == LOCK) && !fifo_full && !flush && !sclr;
        req_ready  = lock_open ? (4'b0001 << owner_q) : 4'b0000;
        xfer       = lock_open && req_valid[owner_q];
        fifo_wrreq = xfer;
        fifo_data  = ((state_q == LOCK) && !sclr) ? req_data[{owner_q, 3'b000} +: 8] : 8'h00;
        busy       = !sclr && (state_q != IDLE);
        burst_inc  = (burst_cnt_q == 8'hFF) ? 8'hFF : burst_cnt_q + 8'd1;
    end

    // Next-state logic: flush overrides every other transition.
    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        last_owner_d  = last_owner_q;
        burst_cnt_d   = burst_cnt_q;
        grant_id_d    = grant_id_q;
        clr_cnt_d     = clr_cnt_q;
        fifo_sclr_n_d = 1'b1;
        if (flush) begin
            state_d       = FLUSH;
            clr_cnt_d     = 1'b1;
            fifo_sclr_n_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_valid) begin
                        owner_d     = pick_idx;
                        grant_id_d  = pick_idx;
                        burst_cnt_d = 8'd0;
                        state_d     = LOCK;
                    end
                end
                LOCK: begin
                    if (xfer) begin
                        burst_cnt_d = burst_inc;
                        if (req_last[owner_q] || (burst_inc == MAX_BURST_B)) begin
                            last_owner_d = owner_q;
                            state_d      = IDLE;
                        end
                    end
                end
                FLUSH: begin
                    if (clr_cnt_q) begin
                        clr_cnt_d     = 1'b0;
                        fifo_sclr_n_d = 1'b0;
                    end else begin
                        state_d      = IDLE;
                        last_owner_d = 2'd3;
                        burst_cnt_d  = 8'd0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State registers with synchronous reset; the FIFO clear is held during reset.
    always_ff @(posedge clock) begin
        if (sclr) begin
            state_q       <= IDLE;
            owner_q       <= 2'd0;
            last_owner_q  <= 2'd3;
            burst_cnt_q   <= 8'd0;
            grant_id_q    <= 2'd0;
            clr_cnt_q     <= 1'b0;
            fifo_sclr_n_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            last_owner_q  <= last_owner_d;
            burst_cnt_q   <= burst_cnt_d;
            grant_id_q    <= grant_id_d;
            clr_cnt_q     <= clr_cnt_d;
            fifo_sclr_n_q <= fifo_sclr_n_d;
        end
    end

    assign grant_id    = grant_id_q;
    assign fifo_sclr_n = fifo_sclr_n_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized bench for fifo_wr_arbiter: a behavioural model predicts every
// FIFO write into a scoreboard queue that a separate monitor drains.
module tb_fifo_wr_arbiter;

    localparam int MAXB = 16;

    logic        clock;
    logic        sclr;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic        flush;
    logic        fifo_full;
    logic        fifo_wrreq;
    logic [7:0]  fifo_data;
    logic        fifo_sclr_n;
    logic [1:0]  grant_id;
    logic        busy;

    fifo_wr_arbiter #(.MAX_BURST(MAXB)) dut (
        .clock       (clock),
        .sclr        (sclr),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .flush       (flush),
        .fifo_full   (fifo_full),
        .fifo_wrreq  (fifo_wrreq),
        .fifo_data   (fifo_data),
        .fifo_sclr_n (fifo_sclr_n),
        .grant_id    (grant_id),
        .busy        (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    // Expected writes: {requester index, byte}.
    logic [9:0] exp_q[$];

    // Model: mode 0 = waiting for requests, 1 = a requester owns the FIFO,
    // 2 = clearing the FIFO.
    int   m_mode, m_owner, m_grant, m_rr, m_count, m_clears;
    bit   m_sclr_n;
    bit   m_known = 0;
    bit   m_open, e_wr, e_busy;
    logic [3:0] e_ready;
    logic [7:0] e_data;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %0h, want %0h", name, cyc, act, exp);
        end
    endtask

    // Stimulus phases: cycles, valid %, last %, full %, flush %, sclr %, requester mask.
    int ph_cyc [7] = '{4, 400, 400, 1500, 1500, 3, 8};
    int ph_pv  [7] = '{50, 100, 100, 70, 40, 50, 0};
    int ph_pl  [7] = '{50, 100, 0, 15, 5, 50, 0};
    int ph_pf  [7] = '{0, 0, 0, 25, 10, 0, 0};
    int ph_pfl [7] = '{0, 0, 0, 2, 3, 0, 0};
    int ph_ps  [7] = '{100, 0, 0, 1, 0, 100, 0};
    int ph_msk [7] = '{15, 15, 4, 15, 15, 15, 0};

    int r;

    initial begin
        sclr = 1'b1; flush = 1'b0; fifo_full = 1'b0;
        req_valid = '0; req_data = '0; req_last = '0;
        m_mode = 0; m_owner = 0; m_grant = 0; m_rr = 3; m_count = 0; m_clears = 0;
        m_sclr_n = 1'b0;
        for (int p = 0; p < 7; p++) begin
            for (int c = 0; c < ph_cyc[p]; c++) begin
                @(negedge clock);
                cyc++;
                for (int i = 0; i < 4; i++) begin
                    req_valid[i] = ph_msk[p][i] && ($urandom_range(99) < 32'(ph_pv[p]));
                    req_last[i]  = $urandom_range(99) < 32'(ph_pl[p]);
                end
                req_data  = $urandom;
                fifo_full = $urandom_range(99) < 32'(ph_pf[p]);
                flush     = $urandom_range(99) < 32'(ph_pfl[p]);
                sclr      = $urandom_range(99) < 32'(ph_ps[p]);
                #1;
                m_open  = (m_mode == 1) && !fifo_full && !flush && !sclr;
                e_ready = m_open ? 4'(1 << m_owner) : 4'd0;
                e_wr    = m_open && req_valid[m_owner];
                e_data  = (m_mode == 1 && !sclr) ? req_data[m_owner*8 +: 8] : 8'h00;
                e_busy  = !sclr && (m_mode != 0);
                if (m_known) begin
                    if (e_wr) exp_q.push_back({2'(m_owner), e_data});
                    check("req_ready", 32'(req_ready), 32'(e_ready));
                    check("busy", 32'(busy), 32'(e_busy));
                    check("grant_id", 32'(grant_id), 32'(m_grant));
                    check("fifo_sclr_n", 32'(fifo_sclr_n), 32'(m_sclr_n));
                    check("fifo_data", 32'(fifo_data), 32'(e_data));
                end
                @(posedge clock);
                if (sclr) begin
                    m_mode = 0; m_owner = 0; m_grant = 0; m_rr = 3; m_count = 0;
                    m_clears = 0; m_sclr_n = 1'b0; m_known = 1;
                end else begin
                    m_sclr_n = 1'b1;
                    if (flush) begin
                        m_mode = 2; m_clears = 2; m_sclr_n = 1'b0;
                    end else if (m_mode == 0) begin
                        for (int k = 1; k <= 4; k++) begin
                            r = (m_rr + k) % 4;
                            if (m_mode == 0 && req_valid[r]) begin
                                m_owner = r; m_grant = r; m_count = 0; m_mode = 1;
                            end
                        end
                    end else if (m_mode == 1) begin
                        if (e_wr) begin
                            m_count++;
                            if (req_last[m_owner] || m_count == MAXB) begin
                                m_rr = m_owner; m_mode = 0;
                            end
                        end
                    end else begin
                        m_clears--;
                        if (m_clears > 0) m_sclr_n = 1'b0;
                        else begin
                            m_mode = 0; m_rr = 3; m_count = 0;
                        end
                    end
                end
            end
        end
        @(negedge clock);
        #3;
        check("writes_outstanding", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Monitor: every DUT write must match the oldest predicted write.
    logic [9:0] got_w, exp_w;
    always begin
        @(negedge clock);
        #2;
        if (m_known) begin
            if (fifo_wrreq === 1'b1) begin
                n_cmp++;
                got_w = {grant_id, fifo_data};
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL write_unexpected cycle %0d: got %0h, want none", cyc, got_w);
                end else begin
                    exp_w = exp_q.pop_front();
                    if (got_w !== exp_w) begin
                        n_err++;
                        $display("FAIL write_data cycle %0d: got %0h, want %0h", cyc, got_w, exp_w);
                    end
                end
            end else if (exp_q.size() != 0) begin
                n_cmp++;
                n_err++;
                exp_w = exp_q.pop_front();
                $display("FAIL write_missing cycle %0d: got wrreq=%b, want write %0h",
                         cyc, fifo_wrreq, exp_w);
            end
        end
    end

endmodule
